change_dispenser: RTL
=====================

# change_dispenser

Output stage of the ticket vending machine. After the fare FSM has collected enough money, this block receives the change owed and the ticket count. It pays out the change as discrete coins, largest denomination first (50/10/5/1), over a valid/ack handshake to the coin mechanism, then issues tickets one at a time over a second handshake. It reports completion with a one-cycle pulse.

## Interface
- CHANGE_W, 7: width of change amount and running total
- TICKET_W, 3: width of ticket count
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- changeIn  in  CHANGE_W  change owed, latched on accepted start
- ticketsIn  in  TICKET_W  tickets to issue, latched on accepted start
- coinAck  in  1  coin mechanism took current coin
- ticketAck  in  1  ticket printer took current ticket
- coinValid  out  1  coinValue is presented
- coinValue  out  6  denomination: 50, 10, 5 or 1
- ticketValid  out  1  one ticket is requested
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- totalDispensed  out  CHANGE_W  sum of coins acked since last accepted start

## Operation
- States: IDLE, SELECT, COIN, TICKET, DONE.
- IDLE:
  - On start=1: latch remaining<=changeIn and ticketsLeft<=ticketsIn, clear totalDispensed, go to SELECT.
  - start=0: stay in IDLE.
- SELECT (one cycle), decided on the registered remaining value:
  - remaining=0: go to TICKET.
  - remaining≥50: register coinValue=50.
  - else remaining≥10: register coinValue=10.
  - else remaining≥5: register coinValue=5.
  - else: register coinValue=1.
  - In every nonzero case, go to COIN.
- COIN:
  - coinValid=1; coinValue holds stable until acked.
  - On coinAck: remaining-=coinValue, totalDispensed+=coinValue, go to SELECT.
  - coinAck while coinValid=0 is ignored.
- TICKET:
  - ticketsLeft=0: go to DONE with no ticketValid.
  - Otherwise ticketValid=1; on ticketAck decrement ticketsLeft. When the count reaches 0, go to DONE.
- DONE: done=1 for one cycle, go to IDLE.
- totalDispensed holds its value in IDLE until the next accepted start.
- Arithmetic:
  - Unsigned subtraction never underflows, because the coin is always ≤ remaining.
  - totalDispensed never exceeds changeIn ≤ 127.
- ticketsIn is used as given (0–7); range checking is upstream's job.
- start while busy=1 is ignored and not queued.

## Timing
- Reset (synchronous) drives:
  - state=IDLE
  - coinValid=0, coinValue=0, ticketValid=0, busy=0, done=0
  - totalDispensed=0, remaining=0, ticketsLeft=0
- Reset mid-operation abandons any pending coins or tickets; no done pulse is generated.
- start accepted at edge t:
  - busy=1 from t+1.
  - SELECT occupies cycle t+1.
  - First coinValid at t+2.
- Each coin costs 1 SELECT cycle plus ≥1 COIN cycle; with coinAck tied high, throughput is one coin per 2 cycles.
- Each ticket: ticketValid is held until ticketAck; with ticketAck tied high, throughput is one ticket per cycle.
- done asserts the cycle after the last ticketAck, or the cycle after TICKET entry if ticketsLeft=0. busy stays 1 during DONE.
- coinValue, coinValid, ticketValid and done are all registered outputs.

## Configuration
- CHANGE_DISPENSER_TICKET_EN:
  - Defined: TICKET state present, behaving as above.
  - Undefined: remaining=0 in SELECT goes directly to DONE. ticketValid is tied 0, ticketAck and ticketsIn are unused, and the ticketsLeft register is removed.

## Structure
- Shared package vending_pkg holds:
  - state enum for IDLE/SELECT/COIN/TICKET/DONE
  - denomination constants COIN_50=50, COIN_10=10, COIN_5=5, COIN_1=1
  - CHANGE_W and TICKET_W defaults
- One combinational sub-module, coin_select: remaining in, largest denomination ≤ remaining out (0 when remaining=0). It is instantiated once and used in SELECT.

## Test plan
- changeIn=37, ticketsIn=2, acks tied high:
  - coins 10,10,10,5,1,1 in order
  - then 2 ticketValid cycles, then a done pulse
  - totalDispensed=37
- changeIn=0, ticketsIn=3:
  - no coinValid
  - 3 tickets, done
  - totalDispensed=0
- changeIn=127:
  - coins 50,50,10,10,5,1,1
  - coinAck withheld 4 cycles on the second coin; coinValue is held at 50 and coinValid stays high throughout
- Reset asserted while in COIN after 2 coins:
  - next cycle all outputs are 0 and state is IDLE; no done pulse
  - a fresh start with changeIn=6 gives coins 5,1
- start pulsed while busy with changeIn=99: ignored; the original transaction completes unchanged.
- Macro undefined, changeIn=15, ticketsIn=4: coins 10,5, then done; ticketValid never rises.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and constants for the ticket vending machine output stage.
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    COIN,
    TICKET,
    DONE
  } state_t;

  localparam logic [5:0] COIN_50 = 6'd50;
  localparam logic [5:0] COIN_10 = 6'd10;
  localparam logic [5:0] COIN_5  = 6'd5;
  localparam logic [5:0] COIN_1  = 6'd1;

  localparam int CHANGE_W_DEFAULT = 7;
  localparam int TICKET_W_DEFAULT = 3;

endpackage

// File: rtl/change_dispenser_if.sv
// Handshake bundle between the fare FSM / coin mechanism / printer side and the dispenser.
interface change_dispenser_if
  import vending_pkg::*;
#(
  parameter int CHANGE_W = CHANGE_W_DEFAULT,
  parameter int TICKET_W = TICKET_W_DEFAULT
) ();

  logic                start;
  logic [CHANGE_W-1:0] changeIn;
  logic [TICKET_W-1:0] ticketsIn;
  logic                coinAck;
  logic                ticketAck;
  logic                coinValid;
  logic [5:0]          coinValue;
  logic                ticketValid;
  logic                busy;
  logic                done;
  logic [CHANGE_W-1:0] totalDispensed;

  modport master (
    output start, changeIn, ticketsIn, coinAck, ticketAck,
    input  coinValid, coinValue, ticketValid, busy, done, totalDispensed
  );

  modport slave (
    input  start, changeIn, ticketsIn, coinAck, ticketAck,
    output coinValid, coinValue, ticketValid, busy, done, totalDispensed
  );

endinterface

// File: rtl/coin_select.sv
// Picks the largest denomination that does not exceed the remaining change (0 when nothing is owed).
module coin_select
  import vending_pkg::*;
#(
  parameter int CHANGE_W = CHANGE_W_DEFAULT
) (
  input  logic [CHANGE_W-1:0] remaining,
  output logic [5:0]          coin
);

  always_comb begin
    coin = '0;
    if (remaining >= CHANGE_W'(COIN_50))     coin = COIN_50;
    else if (remaining >= CHANGE_W'(COIN_10)) coin = COIN_10;
    else if (remaining >= CHANGE_W'(COIN_5))  coin = COIN_5;
    else if (remaining != '0)                 coin = COIN_1;
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out change largest coin first, then issues tickets, then pulses done.
// Ticket issue stage is built only when CHANGE_DISPENSER_TICKET_EN is defined.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int CHANGE_W = CHANGE_W_DEFAULT,
  parameter int TICKET_W = TICKET_W_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  change_dispenser_if.slave bus
);

  state_t              state, stateNext;
  logic [CHANGE_W-1:0] remaining, remainingNext;
  logic [CHANGE_W-1:0] total, totalNext;
  logic [5:0]          coinValueReg, coinValueNext, selCoin;
  logic                coinValidReg, coinValidNext;
  logic                doneReg, doneNext;
`ifdef CHANGE_DISPENSER_TICKET_EN
  logic [TICKET_W-1:0] ticketsLeft, ticketsLeftNext;
  logic                ticketValidReg, ticketValidNext;
`else
  logic                unusedTicketInputs;
  assign unusedTicketInputs = ^{bus.ticketAck, bus.ticketsIn};
`endif

  coin_select #(.CHANGE_W(CHANGE_W)) u_coin_select (
    .remaining(remaining),
    .coin     (selCoin)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      remaining    <= '0;
      total        <= '0;
      coinValueReg <= '0;
      coinValidReg <= 1'b0;
      doneReg      <= 1'b0;
`ifdef CHANGE_DISPENSER_TICKET_EN
      ticketsLeft    <= '0;
      ticketValidReg <= 1'b0;
`endif
    end else begin
      state        <= stateNext;
      remaining    <= remainingNext;
      total        <= totalNext;
      coinValueReg <= coinValueNext;
      coinValidReg <= coinValidNext;
      doneReg      <= doneNext;
`ifdef CHANGE_DISPENSER_TICKET_EN
      ticketsLeft    <= ticketsLeftNext;
      ticketValidReg <= ticketValidNext;
`endif
    end
  end

  // Registered outputs are derived from the state being entered, so they line up with it.
  always_comb begin
    stateNext     = state;
    remainingNext = remaining;
    totalNext     = total;
    coinValueNext = coinValueReg;
`ifdef CHANGE_DISPENSER_TICKET_EN
    ticketsLeftNext = ticketsLeft;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          stateNext     = SELECT;
          remainingNext = bus.changeIn;
          totalNext     = '0;
`ifdef CHANGE_DISPENSER_TICKET_EN
          ticketsLeftNext = bus.ticketsIn;
`endif
        end
      end
      SELECT: begin
        if (remaining == '0) begin
`ifdef CHANGE_DISPENSER_TICKET_EN
          stateNext = TICKET;
`else
          stateNext = DONE;
`endif
        end else begin
          coinValueNext = selCoin;
          stateNext     = COIN;
        end
      end
      COIN: begin
        if (bus.coinAck && coinValidReg) begin
          remainingNext = remaining - CHANGE_W'(coinValueReg);
          totalNext     = total + CHANGE_W'(coinValueReg);
          stateNext     = SELECT;
        end
      end
`ifdef CHANGE_DISPENSER_TICKET_EN
      TICKET: begin
        if (ticketsLeft == '0) begin
          stateNext = DONE;
        end else if (bus.ticketAck && ticketValidReg) begin
          ticketsLeftNext = ticketsLeft - TICKET_W'(1);
          if (ticketsLeft == TICKET_W'(1)) stateNext = DONE;
        end
      end
`endif
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    coinValidNext = (stateNext == COIN);
    doneNext      = (stateNext == DONE);
`ifdef CHANGE_DISPENSER_TICKET_EN
    ticketValidNext = (stateNext == TICKET) && (ticketsLeftNext != '0);
`endif
  end

  assign bus.coinValid      = coinValidReg;
  assign bus.coinValue      = coinValueReg;
  assign bus.done           = doneReg;
  assign bus.busy           = (state != IDLE);
  assign bus.totalDispensed = total;
`ifdef CHANGE_DISPENSER_TICKET_EN
  assign bus.ticketValid = ticketValidReg;
`else
  assign bus.ticketValid = 1'b0;
`endif

endmodule
